eq_cmp_arbiter: RTL

EQ_CMP_ARBITER -- requirements
Module: eq_cmp_arbiter

---
 rtl/eq_cmp_pkg.sv | 15 +
 rtl/eq_cmp_core.sv | 16 +
 rtl/eq_cmp_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/eq_cmp_pkg.sv
// Shared types and helpers for the round-robin equality-compare arbiter.
package eq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a requester count; kept at least 1 bit so NREQ=2 still works.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eq_cmp_core.sv
// Combinational equality comparator: eq/ne flags and A-if-equal-else-B select.
module eq_cmp_core #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         ne,
  output logic [W-1:0] sel
);

  assign eq  = (a == b);
  assign ne  = ~eq;
  assign sel = eq ? a : b;

endmodule

// File: rtl/eq_cmp_arbiter.sv
// Round-robin arbiter sharing one equality comparator among NREQ requesters.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant the round-robin winner combinationally
// CMP   | latched operands go through the comparator; result registered at exit
// RESP  | rsp_valid held until rsp_ready; rsp_* stable while stalled
module eq_cmp_arbiter
  import eq_cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int CNTW = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*W-1:0]              req_a,
  input  logic [NREQ*W-1:0]              req_b,
  output logic [NREQ-1:0]                req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [idx_width(NREQ)-1:0]     rsp_id,
  output logic                           rsp_eq,
  output logic                           rsp_ne,
  output logic [W-1:0]                   rsp_sel,
  output logic                           busy,
  output logic [CNTW-1:0]                match_cnt
);

  localparam int IW = idx_width(NREQ);

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [IW-1:0] lat_id;
  logic [W-1:0]  lat_a, lat_b;
  logic          core_eq, core_ne;
  logic [W-1:0]  core_sel;
  logic          accept;
  logic          handshake;

  // Search from last+1 upward with wrap; iterating offsets high-to-low lets the
  // nearest requester overwrite farther ones.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [IW-1:0]   last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NREQ;
      if (valid[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign {win_found, win_idx} = rr_pick(req_valid, last_grant);
  assign accept    = (state == IDLE) && win_found;
  assign handshake = (state == RESP) && rsp_valid && rsp_ready;

  eq_cmp_core #(.W(W)) u_core (
    .a   (lat_a),
    .b   (lat_b),
    .eq  (core_eq),
    .ne  (core_ne),
    .sel (core_sel)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CMP;
      CMP:     state_nxt = RESP;
      RESP:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and busy outputs; grant is suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if ((state == IDLE) && rst_n && win_found) req_ready[win_idx] = 1'b1;
  end

  // Capture the winner's operands and index, and remember it for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NREQ - 1);
      lat_id     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
    end else if (accept) begin
      last_grant <= win_idx;
      lat_id     <= win_idx;
      lat_a      <= req_a[int'(win_idx)*W +: W];
      lat_b      <= req_b[int'(win_idx)*W +: W];
    end
  end

  // Register the comparator result leaving CMP; hold it through any RESP stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_ne    <= 1'b0;
      rsp_sel   <= '0;
    end else if (state == CMP) begin
      rsp_valid <= 1'b1;
      rsp_id    <= lat_id;
      rsp_eq    <= core_eq;
      rsp_ne    <= core_ne;
      rsp_sel   <= core_sel;
    end else if (handshake) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating count of delivered equal results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_cnt <= '0;
    else if (handshake && rsp_eq && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
  end

endmodule
